// File: rtl/mic1_uart_loader.sv
// mic1_uart_loader: UART 8N1 program loader for the MIC-1 core.
// Receives a framed image (A5, count, words, xor) and writes it to memory.
// Ports:
//   CLK, RST   - clock, synchronous active-high reset
//   RX         - asynchronous UART input, idle high
//   MEM_WE     - one-cycle write strobe; MEM_ADDR/MEM_WDATA hold until next write
//   CPU_RST    - holds the core in reset until a verified load completes
//   DONE, ERR  - sticky load status
module mic1_uart_loader #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    output logic              CPU_RST,
    output logic              DONE,
    output logic              ERR
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(DIV - 1);
    localparam logic [16:0]   MAX_N = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        L_HDR, L_CNTH, L_CNTL, L_DH, L_DL, L_CK, L_DONE, L_ERR
    } ld_state_t;

    logic            rx_m;
    logic            rx_s;
    rx_state_t       rstate;
    logic [TW-1:0]   tmr;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            byte_valid;
    logic            frame_err;

    ld_state_t       lstate;
    logic [15:0]     cnt;
    logic [ADDR_W:0] idx;
    logic [7:0]      hi;
    logic [7:0]      csum;
    logic [15:0]     cnt_full;
    logic [ADDR_W:0] idx_inc;

    assign cnt_full = {cnt[15:8], shreg};
    assign idx_inc  = idx + ONE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    // Receiver: sample mid-bit; shreg holds the byte while byte_valid is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rstate     <= R_IDLE;
            tmr        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (rstate)
                R_IDLE: begin
                    if (!rx_s) begin
                        tmr    <= HALF;
                        rstate <= R_START;
                    end
                end
                R_START: begin
                    if (tmr == '0) begin
                        if (!rx_s) begin
                            tmr     <= FULL;
                            bit_idx <= '0;
                            rstate  <= R_DATA;
                        end else begin
                            rstate <= R_IDLE;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                R_DATA: begin
                    if (tmr == '0) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        tmr     <= FULL;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rstate <= R_STOP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                R_STOP: begin
                    if (tmr == '0) begin
                        byte_valid <= rx_s;
                        frame_err  <= !rx_s;
                        rstate     <= R_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
            endcase
        end
    end

    // Loader: running xor covers both count bytes and every data byte.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lstate    <= L_HDR;
            cnt       <= '0;
            idx       <= '0;
            hi        <= '0;
            csum      <= '0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            CPU_RST   <= 1'b1;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            MEM_WE <= 1'b0;
            if (frame_err && lstate != L_DONE) begin
                lstate <= L_ERR;
                ERR    <= 1'b1;
            end else if (byte_valid) begin
                unique case (lstate)
                    L_HDR: begin
                        if (shreg == 8'hA5) lstate <= L_CNTH;
                    end
                    L_CNTH: begin
                        cnt[15:8] <= shreg;
                        csum      <= csum ^ shreg;
                        lstate    <= L_CNTL;
                    end
                    L_CNTL: begin
                        cnt  <= cnt_full;
                        csum <= csum ^ shreg;
                        idx  <= '0;
                        if (cnt_full == '0 || {1'b0, cnt_full} > MAX_N) begin
                            lstate <= L_ERR;
                            ERR    <= 1'b1;
                        end else begin
                            lstate <= L_DH;
                        end
                    end
                    L_DH: begin
                        hi     <= shreg;
                        csum   <= csum ^ shreg;
                        lstate <= L_DL;
                    end
                    L_DL: begin
                        MEM_WE    <= 1'b1;
                        MEM_ADDR  <= idx[ADDR_W-1:0];
                        MEM_WDATA <= {hi, shreg};
                        csum      <= csum ^ shreg;
                        idx       <= idx_inc;
                        lstate    <= (16'(idx_inc) == cnt) ? L_CK : L_DH;
                    end
                    L_CK: begin
                        if (shreg == csum) begin
                            lstate  <= L_DONE;
                            DONE    <= 1'b1;
                            CPU_RST <= 1'b0;
                        end else begin
                            lstate <= L_ERR;
                            ERR    <= 1'b1;
                        end
                    end
                    L_DONE: ;
                    L_ERR:  ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mic1_uart_loader.sv
// tb_mic1_uart_loader: serial stimulus for mic1_uart_loader, checked
// against a byte-stream parser model of the frame format.
module tb_mic1_uart_loader;
    localparam int DIV = 16;
    localparam int AW  = 4;

    typedef struct {
        logic [7:0] b;
        bit         bad;
    } item_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX  = 1'b1;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [15:0]   MEM_WDATA;
    logic          CPU_RST;
    logic          DONE;
    logic          ERR;

    item_t       tx[$];
    item_t       stim[$];
    logic [15:0] wq[$];
    int          wa[$];
    int          wd[$];
    int          ea[$];
    int          ed[$];
    bit          edone;
    bit          eerr;
    int          n_chk = 0;
    int          n_fail = 0;

    mic1_uart_loader #(
        .CLK_FREQ(16),
        .BAUD    (1),
        .ADDR_W  (AW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX       (RX),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WDATA(MEM_WDATA),
        .CPU_RST  (CPU_RST),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (MEM_WE) begin
            wa.push_back(int'(MEM_ADDR));
            wd.push_back(int'(MEM_WDATA));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input bit bad = 1'b0);
        tx.push_back('{b, bad});
    endtask

    task automatic add_frame(input logic [15:0] n, input bit good);
        logic [7:0] cs;
        cs = n[15:8] ^ n[7:0];
        add(8'hA5);
        add(n[15:8]);
        add(n[7:0]);
        foreach (wq[i]) begin
            add(wq[i][15:8]);
            add(wq[i][7:0]);
            cs = cs ^ wq[i][15:8] ^ wq[i][7:0];
        end
        if (!good) cs = cs ^ 8'($urandom_range(1, 255));
        add(cs);
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad, input int gap);
        RX = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (DIV) @(negedge CLK);
        end
        RX = !bad;
        repeat (DIV) @(negedge CLK);
        RX = 1'b1;
        repeat (gap * DIV) @(negedge CLK);
    endtask

    task automatic flush(input int gapmax);
        int g;
        while (tx.size() > 0) begin
            item_t it;
            it = tx.pop_front();
            g = $urandom_range(0, gapmax);
            if (it.bad && g == 0) g = 1;
            stim.push_back(it);
            send_byte(it.b, it.bad, g);
        end
    endtask

    task automatic rst_pulse();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        stim.delete();
        tx.delete();
    endtask

    task automatic start(input bit clear_writes = 1'b1);
        rst_pulse();
        if (clear_writes) begin
            wa.delete();
            wd.delete();
        end
    endtask

    // Reference: parse the delivered byte stream by frame rules.
    task automatic model();
        int lim;
        int h;
        int n;
        int p;
        bit fe;
        logic [7:0] cs;
        ea.delete();
        ed.delete();
        edone = 1'b0;
        eerr  = 1'b0;
        lim = stim.size();
        for (int i = stim.size() - 1; i >= 0; i--)
            if (stim[i].bad) lim = i;
        fe = lim < stim.size();
        h = -1;
        for (int i = lim - 1; i >= 0; i--)
            if (stim[i].b == 8'hA5) h = i;
        if (h < 0 || h + 2 >= lim) begin
            eerr = fe;
            return;
        end
        n  = int'({stim[h+1].b, stim[h+2].b});
        cs = stim[h+1].b ^ stim[h+2].b;
        if (n == 0 || n > 2 ** AW) begin
            eerr = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            p = h + 3 + 2 * w;
            if (p + 1 >= lim) begin
                eerr = fe;
                return;
            end
            ea.push_back(w);
            ed.push_back(int'({stim[p].b, stim[p+1].b}));
            cs = cs ^ stim[p].b ^ stim[p+1].b;
        end
        p = h + 3 + 2 * n;
        if (p >= lim) begin
            eerr = fe;
            return;
        end
        edone = stim[p].b == cs;
        eerr  = !edone;
    endtask

    task automatic verify(input string tag);
        repeat (2 * DIV) @(negedge CLK);
        model();
        chk({tag, ".nwr"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), wa[i], ea[i]);
            chk($sformatf("%s.data%0d", tag, i), wd[i], ed[i]);
        end
        chk({tag, ".done"}, DONE, edone);
        chk({tag, ".err"}, ERR, eerr);
        chk({tag, ".cpu_rst"}, CPU_RST, !edone);
    endtask

    initial begin
        int n;
        int k;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst.we", MEM_WE, 1'b0);
        chk("rst.addr", MEM_ADDR, '0);
        chk("rst.wdata", MEM_WDATA, 16'h0);
        chk("rst.cpu_rst", CPU_RST, 1'b1);
        chk("rst.done", DONE, 1'b0);
        chk("rst.err", ERR, 1'b0);

        start();
        wq = '{16'h1234, 16'hABCD};
        add_frame(16'd2, 1'b1);
        flush(0);
        verify("basic");
        chk("basic.done_lit", DONE, 1'b1);

        start();
        add(8'hA5); add(8'h00); add(8'h01);
        add(8'h00); add(8'hFF); add(8'h00);
        flush(1);
        verify("badck");
        chk("badck.err_lit", ERR, 1'b1);

        start();
        add(8'h00); add(8'h5A);
        wq = '{16'hBEEF};
        add_frame(16'd1, 1'b1);
        flush(1);
        verify("garbage");

        start();
        add(8'hA5); add(8'h00); add(8'h00);
        flush(0);
        verify("cnt0");

        start();
        add(8'hA5); add(8'h00); add(8'(2 ** AW + 1));
        flush(0);
        verify("cnt_over");

        start();
        rand_words(2 ** AW);
        add_frame(16'(2 ** AW), 1'b1);
        flush(0);
        verify("cnt_max");
        if (wa.size() > 0)
            chk("cnt_max.last", wa[wa.size()-1], 2 ** AW - 1);
        else
            chk("cnt_max.last", 32'hFFFF_FFFF, 2 ** AW - 1);

        start();
        add(8'hA5);
        flush(0);
        RX = 1'b0;
        repeat (4) @(negedge CLK);
        RX = 1'b1;
        repeat (3 * DIV) @(negedge CLK);
        add(8'h00); add(8'h01); add(8'hBE); add(8'hEF);
        add(8'h01 ^ 8'hBE ^ 8'hEF);
        flush(0);
        verify("glitch");
        chk("glitch.done_lit", DONE, 1'b1);

        start();
        add(8'hA5); add(8'h00); add(8'h02); add(8'h12); add(8'h34);
        add(8'h56, 1'b1);
        add(8'h78);
        flush(0);
        verify("framing");

        start();
        add(8'hA5); add(8'h00); add(8'h02); add(8'h12);
        flush(0);
        rst_pulse();
        wq = '{16'hCAFE, 16'h0042};
        add_frame(16'd2, 1'b1);
        wq = '{16'h1111};
        add_frame(16'd1, 1'b1);
        flush(0);
        verify("midrst");

        for (int it = 0; it < 6; it++) begin
            start();
            k = $urandom_range(0, 2);
            for (int g = 0; g < k; g++) add(8'($urandom_range(0, 8'hA4)));
            k = $urandom_range(0, 9);
            n = (k == 0) ? 0 : (k == 9) ? 2 ** AW + 1 : k;
            if (n == 0 || n > 2 ** AW) begin
                add(8'hA5); add(8'(n >> 8)); add(8'(n));
            end else begin
                rand_words(n);
                add_frame(16'(n), $urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 4) == 0)
                tx[$urandom_range(0, tx.size() - 1)].bad = 1'b1;
            flush(2);
            verify($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
